// File: rtl/fetch.sv
// Fetch stage for the barrel-threaded pipeline: one PC per hardware thread,
// round-robin issue over the enabled threads, and redirects from execute.
module fetch #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned NUM_THREADS   = 8,
  parameter int unsigned BITS_THREADS  = $clog2(NUM_THREADS),
  parameter logic [31:0] RESET_PC      = 32'h0,
  parameter logic [31:0] THREAD_STRIDE = 32'h100
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_THREADS-1:0]   thread_en,
  input  logic                     pc_src_e,
  input  logic [BITS_THREADS-1:0]  tid_e,
  input  logic [ADDRESS_WIDTH-1:0] pc_target_e,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  output logic                     imem_en,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  output logic [ADDRESS_WIDTH-1:0] pc_f,
  output logic [DATA_WIDTH-1:0]    instr_f,
  output logic [BITS_THREADS-1:0]  tid_f,
  output logic                     valid_f
);

  localparam logic [ADDRESS_WIDTH-1:0] PC_STEP    = ADDRESS_WIDTH'(4);
  localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ~ADDRESS_WIDTH'(3);
  localparam logic [DATA_WIDTH-1:0]    NOP_INSTR  = DATA_WIDTH'(32'h00000013);

  logic [ADDRESS_WIDTH-1:0] pc_q [NUM_THREADS];
  logic [ADDRESS_WIDTH-1:0] pc_d [NUM_THREADS];
  logic [BITS_THREADS-1:0]  cur_tid_q, cur_tid_d;
  logic [ADDRESS_WIDTH-1:0] pc_f_q, pc_f_d;
  logic [BITS_THREADS-1:0]  tid_f_q, tid_f_d;
  logic                     valid_f_q, valid_f_d;

  logic [BITS_THREADS-1:0]  nxt_c;
  logic [BITS_THREADS-1:0]  scan_idx_c;
  logic                     found_c;
  logic                     any_en_c;
  logic                     collide_c;

  // Round-robin pick: first enabled thread after cur_tid, wrapping back to cur_tid last.
  always_comb begin
    nxt_c      = cur_tid_q;
    scan_idx_c = cur_tid_q;
    found_c    = 1'b0;
    for (int k = 1; k <= int'(NUM_THREADS); k++) begin
      scan_idx_c = cur_tid_q + BITS_THREADS'(k);
      if (!found_c && thread_en[scan_idx_c]) begin
        nxt_c   = scan_idx_c;
        found_c = 1'b1;
      end
    end
  end

  assign any_en_c  = |thread_en;
  assign collide_c = pc_src_e && any_en_c && (tid_e == nxt_c);

  assign imem_en   = any_en_c;
  assign imem_addr = any_en_c ? pc_q[nxt_c] : pc_q[cur_tid_q];

  // Next state: issued thread advances by 4; a redirect overrides that increment.
  always_comb begin
    pc_d      = pc_q;
    cur_tid_d = cur_tid_q;
    pc_f_d    = pc_f_q;
    tid_f_d   = tid_f_q;
    valid_f_d = 1'b0;
    if (any_en_c) begin
      cur_tid_d   = nxt_c;
      tid_f_d     = nxt_c;
      pc_f_d      = pc_q[nxt_c];
      valid_f_d   = !collide_c;
      pc_d[nxt_c] = pc_q[nxt_c] + PC_STEP;
    end
    if (pc_src_e) begin
      pc_d[tid_e] = pc_target_e & ALIGN_MASK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_THREADS); i++) begin
        pc_q[i] <= ADDRESS_WIDTH'(RESET_PC) + ADDRESS_WIDTH'(THREAD_STRIDE) * ADDRESS_WIDTH'(i);
      end
      cur_tid_q <= BITS_THREADS'(NUM_THREADS - 1);
      pc_f_q    <= '0;
      tid_f_q   <= '0;
      valid_f_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      cur_tid_q <= cur_tid_d;
      pc_f_q    <= pc_f_d;
      tid_f_q   <= tid_f_d;
      valid_f_q <= valid_f_d;
    end
  end

  assign pc_f    = pc_f_q;
  assign tid_f   = tid_f_q;
  assign valid_f = valid_f_q;
  // Memory data is already registered, so only the squash mux sits on this path.
  assign instr_f = valid_f_q ? imem_rdata : NOP_INSTR;

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: expected slots are queued as stimulus is
// driven and compared once the corresponding fetch slot appears.
module tb_fetch;

  logic        clk;
  logic        rst_n;
  logic [7:0]  thread_en;
  logic        pc_src_e;
  logic [2:0]  tid_e;
  logic [31:0] pc_target_e;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_rdata;
  logic [31:0] pc_f;
  logic [31:0] instr_f;
  logic [2:0]  tid_f;
  logic        valid_f;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [2:0]  tid;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;

  fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .thread_en   (thread_en),
    .pc_src_e    (pc_src_e),
    .tid_e       (tid_e),
    .pc_target_e (pc_target_e),
    .imem_addr   (imem_addr),
    .imem_en     (imem_en),
    .imem_rdata  (imem_rdata),
    .pc_f        (pc_f),
    .instr_f     (instr_f),
    .tid_f       (tid_f),
    .valid_f     (valid_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'hC0DE_0003;
  endfunction

  function automatic logic [31:0] exp_instr(input exp_t x);
    return x.v ? mem_word(x.pc) : 32'h00000013;
  endfunction

  // Synchronous instruction memory, one-cycle read latency.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem_word(imem_addr);
  end

  function automatic exp_t mk(input logic v, input logic [31:0] pc, input logic [2:0] tid);
    exp_t x;
    x.v = v; x.pc = pc; x.tid = tid;
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    thread_en   = 8'h00;
    pc_src_e    = 1'b0;
    tid_e       = 3'd0;
    pc_target_e = 32'h0;
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({valid_f, pc_f, tid_f, instr_f} !== {1'b0, 32'h0, 3'd0, 32'h00000013}) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%0b pc=%h tid=%0d instr=%h, want v=0 pc=0 tid=0 instr=00000013",
               valid_f, pc_f, tid_f, instr_f);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_all_threads();
    do_reset();
    thread_en = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      sb.push_back(mk(1'b1, (i < 8) ? 32'(i) * 32'h100 : 32'h4, 3'(i)));
      n_checks++;
      if (imem_en !== 1'b1) begin
        n_fail++;
        $display("FAIL all_threads_imem_en slot%0d: got %0b want 1", i, imem_en);
      end
      tick();
      e = sb.pop_front();
      n_checks++;
      if ({valid_f, pc_f, tid_f, instr_f} !== {e.v, e.pc, e.tid, exp_instr(e)}) begin
        n_fail++;
        $display("FAIL all_threads slot%0d: got v=%0b pc=%h tid=%0d instr=%h, want v=%0b pc=%h tid=%0d instr=%h",
                 i, valid_f, pc_f, tid_f, instr_f, e.v, e.pc, e.tid, exp_instr(e));
      end
    end
  endtask

  task automatic test_sparse();
    logic [31:0] pcs [12];
    logic [2:0]  tids [12];
    pcs  = '{32'h000, 32'h200, 32'h004, 32'h204, 32'h300, 32'h400, 32'h500, 32'h600,
             32'h700, 32'h008, 32'h100, 32'h208};
    tids = '{3'd0, 3'd2, 3'd0, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      thread_en = (i < 4) ? 8'b0000_0101 : 8'hFF;
      sb.push_back(mk(1'b1, pcs[i], tids[i]));
      tick();
      e = sb.pop_front();
      n_checks++;
      if ({valid_f, pc_f, tid_f, instr_f} !== {e.v, e.pc, e.tid, exp_instr(e)}) begin
        n_fail++;
        $display("FAIL sparse slot%0d: got v=%0b pc=%h tid=%0d instr=%h, want v=%0b pc=%h tid=%0d instr=%h",
                 i, valid_f, pc_f, tid_f, instr_f, e.v, e.pc, e.tid, exp_instr(e));
      end
    end
  endtask

  task automatic test_redirect();
    logic [31:0] base;
    do_reset();
    thread_en = 8'hFF;
    for (int i = 0; i < 12; i++) begin
      pc_src_e    = (i == 0);
      tid_e       = 3'd3;
      pc_target_e = 32'h1003;
      base = (i % 8 == 3) ? 32'h1000 : 32'(i % 8) * 32'h100;
      sb.push_back(mk(1'b1, base + 32'(i / 8) * 32'h4, 3'(i % 8)));
      tick();
      e = sb.pop_front();
      n_checks++;
      if ({valid_f, pc_f, tid_f, instr_f} !== {e.v, e.pc, e.tid, exp_instr(e)}) begin
        n_fail++;
        $display("FAIL redirect slot%0d: got v=%0b pc=%h tid=%0d instr=%h, want v=%0b pc=%h tid=%0d instr=%h",
                 i, valid_f, pc_f, tid_f, instr_f, e.v, e.pc, e.tid, exp_instr(e));
      end
    end
    pc_src_e = 1'b0;
  endtask

  task automatic test_collision();
    logic [31:0] exp_pc;
    do_reset();
    thread_en = 8'hFF;
    for (int i = 0; i < 11; i++) begin
      pc_src_e    = (i == 2);
      tid_e       = 3'd2;
      pc_target_e = 32'h2000;
      exp_pc = (i == 10) ? 32'h2000 : 32'(i % 8) * 32'h100 + 32'(i / 8) * 32'h4;
      sb.push_back(mk(i != 2, exp_pc, 3'(i % 8)));
      tick();
      e = sb.pop_front();
      n_checks++;
      if ({valid_f, pc_f, tid_f, instr_f} !== {e.v, e.pc, e.tid, exp_instr(e)}) begin
        n_fail++;
        $display("FAIL collision slot%0d: got v=%0b pc=%h tid=%0d instr=%h, want v=%0b pc=%h tid=%0d instr=%h",
                 i, valid_f, pc_f, tid_f, instr_f, e.v, e.pc, e.tid, exp_instr(e));
      end
    end
    pc_src_e = 1'b0;
  endtask

  task automatic test_disable();
    logic [31:0] exp_pc;
    logic [2:0]  exp_tid;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      thread_en = (i >= 3 && i < 6) ? 8'h00 : 8'hFF;
      if (i < 3) begin
        exp_pc = 32'(i) * 32'h100; exp_tid = 3'(i);
      end else if (i < 6) begin
        exp_pc = 32'h200; exp_tid = 3'd2;
      end else begin
        exp_tid = 3'(i - 3);
        exp_pc  = (exp_tid == 3'd0) ? 32'h4 : 32'(exp_tid) * 32'h100;
      end
      sb.push_back(mk(!(i >= 3 && i < 6), exp_pc, exp_tid));
      if (i >= 3 && i < 6) begin
        n_checks++;
        if (imem_en !== 1'b0) begin
          n_fail++;
          $display("FAIL disable_imem_en slot%0d: got %0b want 0", i, imem_en);
        end
      end
      tick();
      e = sb.pop_front();
      n_checks++;
      if ({valid_f, pc_f, tid_f, instr_f} !== {e.v, e.pc, e.tid, exp_instr(e)}) begin
        n_fail++;
        $display("FAIL disable slot%0d: got v=%0b pc=%h tid=%0d instr=%h, want v=%0b pc=%h tid=%0d instr=%h",
                 i, valid_f, pc_f, tid_f, instr_f, e.v, e.pc, e.tid, exp_instr(e));
      end
    end
  endtask

  task automatic test_wrap_and_midreset();
    logic [31:0] pcs [5];
    pcs = '{32'h0, 32'hFFFFFFFC, 32'h4, 32'h0, 32'h8};
    do_reset();
    thread_en = 8'h03;
    for (int i = 0; i < 5; i++) begin
      pc_src_e    = (i == 0);
      tid_e       = 3'd1;
      pc_target_e = 32'hFFFFFFFC;
      sb.push_back(mk(1'b1, pcs[i], 3'(i % 2)));
      tick();
      e = sb.pop_front();
      n_checks++;
      if ({valid_f, pc_f, tid_f, instr_f} !== {e.v, e.pc, e.tid, exp_instr(e)}) begin
        n_fail++;
        $display("FAIL wrap slot%0d: got v=%0b pc=%h tid=%0d instr=%h, want v=%0b pc=%h tid=%0d instr=%h",
                 i, valid_f, pc_f, tid_f, instr_f, e.v, e.pc, e.tid, exp_instr(e));
      end
    end
    pc_src_e  = 1'b0;
    thread_en = 8'hFF;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({valid_f, pc_f, tid_f, instr_f, imem_addr} !== {1'b0, 32'h0, 3'd0, 32'h00000013, 32'h0}) begin
      n_fail++;
      $display("FAIL midreset_async: got v=%0b pc=%h tid=%0d instr=%h addr=%h, want v=0 pc=0 tid=0 instr=00000013 addr=0",
               valid_f, pc_f, tid_f, instr_f, imem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(mk(1'b1, 32'(i) * 32'h100, 3'(i)));
      tick();
      e = sb.pop_front();
      n_checks++;
      if ({valid_f, pc_f, tid_f, instr_f} !== {e.v, e.pc, e.tid, exp_instr(e)}) begin
        n_fail++;
        $display("FAIL midreset_restart slot%0d: got v=%0b pc=%h tid=%0d instr=%h, want v=%0b pc=%h tid=%0d instr=%h",
                 i, valid_f, pc_f, tid_f, instr_f, e.v, e.pc, e.tid, exp_instr(e));
      end
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    thread_en   = 8'h00;
    pc_src_e    = 1'b0;
    tid_e       = 3'd0;
    pc_target_e = 32'h0;
    test_reset();
    test_all_threads();
    test_sparse();
    test_redirect();
    test_collision();
    test_disable();
    test_wrap_and_midreset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
